// File: rtl/timer_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : timer_counter                                                 |
// | Brief    : Memory-mapped down-counting timer with interrupt output.      |
// |            Registers: CTRL (idx 0), PRESET (idx 1), COUNT (idx 2, RO).   |
// |            Optional byte-enable writes when TC_BYTEEN_EN is defined.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] C_IDX_CTRL   = 2'd0;
  localparam logic [1:0] C_IDX_PRESET = 2'd1;
  localparam logic [1:0] C_IDX_COUNT  = 2'd2;

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_flag_q, irq_flag_d;

  logic [31:0]      w_mask;
  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic             w_auto;
  logic [31:0]      w_preset_ext;
  logic [31:0]      w_preset_new;
  logic [3:0]       w_ctrl_new;
  logic             unused_ok;

`ifdef TC_BYTEEN_EN
  // Byte lanes merge into CTRL/PRESET; an all-zero byteen is not a write at all.
  assign w_mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign w_wr   = we & (|byteen);
`else
  assign w_mask = 32'hFFFF_FFFF;
  assign w_wr   = we;
`endif

  assign w_wr_ctrl   = w_wr && (addr[3:2] == C_IDX_CTRL);
  assign w_wr_preset = w_wr && (addr[3:2] == C_IDX_PRESET);

  // Only MODE=01 is auto-reload; 10/11 fall back to one-shot.
  assign w_auto = (ctrl_q[2:1] == 2'b01);

  assign w_ctrl_new   = (ctrl_q & ~w_mask[3:0]) | (wdata[3:0] & w_mask[3:0]);
  assign w_preset_new = (w_preset_ext & ~w_mask) | (wdata & w_mask);

  assign irq = ctrl_q[3] & irq_flag_q;

  // Only addr[3:2] is decoded; byteen matters only in the byte-enable build.
  assign unused_ok = &{1'b0, addr[31:4], addr[1:0], byteen};

  // Zero-extend PRESET to bus width for byte merging.
  always_comb begin
    w_preset_ext              = '0;
    w_preset_ext[CNT_W-1:0]   = preset_q;
  end

  // Combinational read mux; index 3 reads zero.
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      C_IDX_CTRL:   rdata[3:0]       = ctrl_q;
      C_IDX_PRESET: rdata[CNT_W-1:0] = preset_q;
      C_IDX_COUNT:  rdata[CNT_W-1:0] = count_q;
      default:      rdata            = '0;
    endcase
  end

  // Next-state: flag clear by bus, then FSM (whose flag set wins), then bus register writes (CTRL write beats INT EN clear).
  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    if ((w_wr_ctrl || w_wr_preset) && !w_auto) begin
      irq_flag_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // PRESET of 0 or 1 lands here directly, so COUNT never wraps.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (w_auto) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_wr_ctrl) begin
      ctrl_d = w_ctrl_new;
    end
    if (w_wr_preset) begin
      preset_d = w_preset_new[CNT_W-1:0];
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_timer_counter                                              |
// | Brief    : Self-checking bench for timer_counter (scoreboard of expected |
// |            COUNT/irq per clock edge). Byte-enable scenario runs only     |
// |            when TC_BYTEEN_EN is defined.                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h8;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  byteen = 4'hF;
  wire  [31:0] rdata;
  wire         irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] cnt;
    logic        irq;
  } exp_t;

  exp_t sb[$];

  timer_counter #(.CNT_W(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr   = a;
    wdata  = d;
    byteen = be;
    we     = 1'b1;
    tick();
    we     = 1'b0;
    byteen = 4'hF;
    addr   = 32'h8;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #4;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    bus_wr(32'h4, 32'd10, 4'hF);
    bus_wr(32'h0, 32'h1, 4'hF);
    repeat (5) tick();
    total++;
    if (rdata !== 32'd7) begin bad++; $display("FAIL reset_precount got=%0d want=7", rdata); end
    reset = 1'b1;
    #1;
    total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL reset_count got=%0h want=0", rdata); end
    addr = 32'h0; #1;
    total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%0h want=0", rdata); end
    addr = 32'h4; #1;
    total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL reset_preset got=%0h want=0", rdata); end
    addr = 32'h8;
    reset = 1'b0;
    tick();
    // irq must drop immediately when reset asserts
    bus_wr(32'h4, 32'd1, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    repeat (3) tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL reset_irq_pre got=%0b want=1", irq); end
    reset = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq_drop got=%0b want=0", irq); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_one_shot();
    exp_t e;
    int   cyc;
    apply_reset();
    bus_wr(32'h4, 32'd3, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd3, 1'b0});
    sb.push_back('{32'd2, 1'b0});
    sb.push_back('{32'd1, 1'b0});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    cyc = 0;
    while (sb.size() > 0) begin
      tick();
      cyc++;
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL oneshot edge=%0d got cnt=%0d irq=%0b want cnt=%0d irq=%0b", cyc, rdata, irq, e.cnt, e.irq);
      end
    end
    addr = 32'h0; #1;
    total++;
    if (rdata !== 32'h8) begin bad++; $display("FAIL oneshot_en_clear ctrl got=%0h want=8", rdata); end
    bus_wr(32'h0, 32'h0, 4'hF);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_ctrl_clear irq got=%0b want=0", irq); end
    bus_wr(32'h0, 32'h8, 4'hF);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_flag_cleared irq got=%0b want=0", irq); end
  endtask

  task automatic test_auto_reload();
    exp_t e;
    int   cyc;
    int   p;
    apply_reset();
    bus_wr(32'h4, 32'd3, 4'hF);
    bus_wr(32'h0, 32'hB, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin
        sb.push_back('{32'd0, 1'b0});
      end else begin
        p = (k - 2) % 6;
        sb.push_back('{(p < 3) ? 32'(3 - p) : 32'd0, (p == 3)});
      end
    end
    cyc = 0;
    while (sb.size() > 0) begin
      tick();
      cyc++;
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL autoreload edge=%0d got cnt=%0d irq=%0b want cnt=%0d irq=%0b", cyc, rdata, irq, e.cnt, e.irq);
      end
    end
    addr = 32'h0; #1;
    total++;
    if (rdata !== 32'hB) begin bad++; $display("FAIL autoreload_ctrl got=%0h want=b", rdata); end
    addr = 32'h8;
  endtask

  task automatic test_stop_mask();
    exp_t e;
    int   cyc;
    apply_reset();
    bus_wr(32'h4, 32'd10, 4'hF);
    bus_wr(32'h0, 32'h1, 4'hF);
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd10, 1'b0});
    sb.push_back('{32'd9, 1'b0});
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt) begin bad++; $display("FAIL stop_count got=%0d want=%0d", rdata, e.cnt); end
    end
    // PRESET change mid-count must not disturb COUNT
    bus_wr(32'h4, 32'd2, 4'hF);
    total++;
    if (rdata !== 32'd8) begin bad++; $display("FAIL stop_preset_midcount got=%0d want=8", rdata); end
    sb.push_back('{32'd7, 1'b0});
    sb.push_back('{32'd6, 1'b0});
    while (sb.size() > 0) begin
      tick();
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt) begin bad++; $display("FAIL stop_count2 got=%0d want=%0d", rdata, e.cnt); end
    end
    bus_wr(32'h0, 32'h0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      total++;
      if (rdata !== 32'd5) begin bad++; $display("FAIL stop_hold i=%0d got=%0d want=5", i, rdata); end
    end
    bus_wr(32'h8, 32'h0000_FFFF, 4'hF);
    total++;
    if (rdata !== 32'd5) begin bad++; $display("FAIL count_readonly got=%0d want=5", rdata); end
    bus_wr(32'hC, 32'h0000_FFFF, 4'hF);
    total++;
    if (rdata !== 32'd5) begin bad++; $display("FAIL idx3_write got=%0d want=5", rdata); end
    addr = 32'hC; #1;
    total++;
    if (rdata !== 32'd0) begin bad++; $display("FAIL idx3_read got=%0h want=0", rdata); end
    addr = 32'h8; #1;
    // masked auto-reload run, reloading from the PRESET written mid-count
    bus_wr(32'h0, 32'h3, 4'hF);
    sb.push_back('{32'd5, 1'b0});
    sb.push_back('{32'd2, 1'b0});
    sb.push_back('{32'd1, 1'b0});
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd2, 1'b0});
    sb.push_back('{32'd1, 1'b0});
    cyc = 0;
    while (sb.size() > 0) begin
      tick();
      cyc++;
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL mask edge=%0d got cnt=%0d irq=%0b want cnt=%0d irq=%0b", cyc, rdata, irq, e.cnt, e.irq);
      end
    end
    // IM set on the edge the flag rises: irq visible for the one-cycle pulse
    bus_wr(32'h0, 32'hB, 4'hF);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%0b want=1", irq); end
    tick();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL unmask_pulse_end got=%0b want=0", irq); end
  endtask

  task automatic test_edges();
    exp_t e;
    int   cyc;
    apply_reset();
    bus_wr(32'h4, 32'd0, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd0, 1'b0});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    sb.push_back('{32'd0, 1'b1});
    cyc = 0;
    while (sb.size() > 0) begin
      tick();
      cyc++;
      e = sb.pop_front();
      total++;
      if (rdata !== e.cnt || irq !== e.irq) begin
        bad++;
        $display("FAIL preset0 edge=%0d got cnt=%0d irq=%0b want cnt=%0d irq=%0b", cyc, rdata, irq, e.cnt, e.irq);
      end
    end
    bus_wr(32'h8, 32'h0000_FFFF, 4'hF);
    total++;
    if (rdata !== 32'd0 || irq !== 1'b1) begin
      bad++; $display("FAIL count_write got cnt=%0h irq=%0b want cnt=0 irq=1", rdata, irq);
    end
    bus_wr(32'h4, 32'd5, 4'hF);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL preset_write_clear got=%0b want=0", irq); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    bus_wr(32'h4, 32'd1, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    repeat (3) tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL b2b_irq got=%0b want=1", irq); end
    // CTRL write lands on the INT edge: EN must survive, flag is cleared
    bus_wr(32'h0, 32'h9, 4'hF);
    addr = 32'h0; #1;
    total++;
    if (rdata !== 32'h9 || irq !== 1'b0) begin
      bad++; $display("FAIL b2b_ctrl_wins got ctrl=%0h irq=%0b want ctrl=9 irq=0", rdata, irq);
    end
    addr = 32'h8;
    repeat (3) tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL b2b_retrigger got=%0b want=1", irq); end
  endtask

`ifdef TC_BYTEEN_EN
  task automatic test_byteen();
    apply_reset();
    bus_wr(32'h4, 32'h1122_3344, 4'hF);
    bus_wr(32'h4, 32'hAABB_CCDD, 4'b0101);
    addr = 32'h4; #1;
    total++;
    if (rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL byteen_merge got=%0h want=11bb33dd", rdata); end
    bus_wr(32'h4, 32'hFFFF_FFFF, 4'b0000);
    addr = 32'h4; #1;
    total++;
    if (rdata !== 32'h11BB_33DD) begin bad++; $display("FAIL byteen_zero got=%0h want=11bb33dd", rdata); end
    bus_wr(32'h4, 32'd1, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    repeat (3) tick();
    bus_wr(32'h0, 32'h0, 4'b0000);
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL byteen_zero_noclear got=%0b want=1", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_stop_mask();
    test_edges();
    test_back_to_back();
`ifdef TC_BYTEEN_EN
    test_byteen();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
